// File: rtl/i2c_slave_regs_if.sv
// Open-drain I2C pin bundle between the bus model (master side) and the
// register target. sda_oe=1 means the target pulls SDA low.
interface i2c_slave_regs_if;
    logic scl_in;
    logic sda_in;
    logic sda_oe;

    modport slave  (input scl_in, input sda_in, output sda_oe);
    modport master (output scl_in, output sda_in, input sda_oe);
endinterface

// File: rtl/i2c_slave_regs.sv
// I2C target exposing NUM_REGS byte registers through an auto-incrementing
// pointer, running from an oversampling system clock (no clock stretching).
module i2c_slave_regs #(
    parameter logic [6:0] SLAVE_ADDR = 7'h42,
    parameter int         NUM_REGS   = 4,
    parameter logic [7:0] REG_RESET  = 8'h00,
    localparam int        IW         = $clog2(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  reset,
    i2c_slave_regs_if.slave       bus,
    output logic [8*NUM_REGS-1:0] reg_out,
    output logic                  wr_strobe,
    output logic [IW-1:0]         wr_index,
    output logic                  busy
);

    typedef enum logic [3:0] {
        IDLE, ADDR, ACK_ADDR, PTR, ACK_PTR, WDATA, ACK_WDATA, RDATA, RACK
    } state_t;

    state_t        state, state_nxt;
    logic          scl_s1, scl_s2, scl_d;
    logic          sda_s1, sda_s2, sda_d;
    logic          scl_rise, scl_fall, start_det, stop_det;
    logic [3:0]    bit_cnt, bit_cnt_nxt;
    logic [7:0]    shreg, shreg_nxt;
    logic [IW-1:0] ptr, ptr_nxt;
    logic          sda_oe_q, oe_nxt;
    logic          busy_nxt, rw, rw_nxt, ack_bit, ack_nxt;
    logic          wr_en, strobe_nxt;
    logic [IW-1:0] idx_nxt;
    logic [7:0]    regs [NUM_REGS];

    // Synchronizers idle high so reset never looks like a bus event.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            {scl_s1, scl_s2, scl_d} <= 3'b111;
            {sda_s1, sda_s2, sda_d} <= 3'b111;
        end else begin
            {scl_s1, scl_s2, scl_d} <= {bus.scl_in, scl_s1, scl_s2};
            {sda_s1, sda_s2, sda_d} <= {bus.sda_in, sda_s1, sda_s2};
        end
    end

    assign scl_rise  =  scl_s2 & ~scl_d;
    assign scl_fall  = ~scl_s2 &  scl_d;
    assign start_det =  scl_s2 &  scl_d &  sda_d & ~sda_s2;
    assign stop_det  =  scl_s2 &  scl_d & ~sda_d &  sda_s2;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            ptr       <= '0;
            sda_oe_q  <= 1'b0;
            busy      <= 1'b0;
            rw        <= 1'b0;
            ack_bit   <= 1'b1;
            wr_strobe <= 1'b0;
            wr_index  <= '0;
        end else begin
            state     <= state_nxt;
            bit_cnt   <= bit_cnt_nxt;
            shreg     <= shreg_nxt;
            ptr       <= ptr_nxt;
            sda_oe_q  <= oe_nxt;
            busy      <= busy_nxt;
            rw        <= rw_nxt;
            ack_bit   <= ack_nxt;
            wr_strobe <= strobe_nxt;
            wr_index  <= idx_nxt;
        end
    end

    // Bytes complete on the SCL fall after the 8th sampled bit, which is
    // also where the ACK drive (and any register write) begins.
    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        shreg_nxt   = shreg;
        ptr_nxt     = ptr;
        oe_nxt      = sda_oe_q;
        busy_nxt    = busy;
        rw_nxt      = rw;
        ack_nxt     = ack_bit;
        wr_en       = 1'b0;
        strobe_nxt  = 1'b0;
        idx_nxt     = wr_index;
        if (stop_det) begin
            state_nxt = IDLE;
            oe_nxt    = 1'b0;
            busy_nxt  = 1'b0;
        end else if (start_det) begin
            state_nxt   = ADDR;
            bit_cnt_nxt = '0;
            oe_nxt      = 1'b0;
            busy_nxt    = 1'b0;
        end else begin
            case (state)
                ADDR, PTR, WDATA: begin
                    if (scl_rise) begin
                        shreg_nxt   = {shreg[6:0], sda_s2};
                        bit_cnt_nxt = bit_cnt + 4'd1;
                    end else if (scl_fall && bit_cnt == 4'd8) begin
                        case (state)
                            ADDR: begin
                                if (shreg[7:1] == SLAVE_ADDR) begin
                                    rw_nxt    = shreg[0];
                                    oe_nxt    = 1'b1;
                                    busy_nxt  = 1'b1;
                                    state_nxt = ACK_ADDR;
                                end else begin
                                    state_nxt = IDLE;
                                end
                            end
                            PTR: begin
                                ptr_nxt   = shreg[IW-1:0];
                                oe_nxt    = 1'b1;
                                state_nxt = ACK_PTR;
                            end
                            default: begin
                                wr_en      = 1'b1;
                                strobe_nxt = 1'b1;
                                idx_nxt    = ptr;
                                ptr_nxt    = ptr + IW'(1);
                                oe_nxt     = 1'b1;
                                state_nxt  = ACK_WDATA;
                            end
                        endcase
                    end
                end
                ACK_ADDR: begin
                    if (scl_fall) begin
                        bit_cnt_nxt = '0;
                        if (rw) begin
                            shreg_nxt = regs[ptr];
                            oe_nxt    = ~regs[ptr][7];
                            state_nxt = RDATA;
                        end else begin
                            oe_nxt    = 1'b0;
                            state_nxt = PTR;
                        end
                    end
                end
                ACK_PTR, ACK_WDATA: begin
                    if (scl_fall) begin
                        bit_cnt_nxt = '0;
                        oe_nxt      = 1'b0;
                        state_nxt   = WDATA;
                    end
                end
                RDATA: begin
                    if (scl_rise) begin
                        bit_cnt_nxt = bit_cnt + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt == 4'd8) begin
                            oe_nxt    = 1'b0;
                            ptr_nxt   = ptr + IW'(1);
                            state_nxt = RACK;
                        end else begin
                            shreg_nxt = {shreg[6:0], 1'b0};
                            oe_nxt    = ~shreg[6];
                        end
                    end
                end
                RACK: begin
                    if (scl_rise) begin
                        ack_nxt = sda_s2;
                    end else if (scl_fall) begin
                        if (!ack_bit) begin
                            bit_cnt_nxt = '0;
                            shreg_nxt   = regs[ptr];
                            oe_nxt      = ~regs[ptr][7];
                            state_nxt   = RDATA;
                        end else begin
                            busy_nxt  = 1'b0;
                            state_nxt = IDLE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NUM_REGS; k++) regs[k] <= REG_RESET;
        end else if (wr_en) begin
            regs[ptr] <= shreg;
        end
    end

    always_comb begin
        reg_out = '0;
        for (int k = 0; k < NUM_REGS; k++) reg_out[8*k +: 8] = regs[k];
    end

    assign bus.sda_oe = sda_oe_q;

endmodule

// File: doc/i2c_slave_regs.md
Name: i2c_slave_regs

Overview:
- I2C target (slave) answering the existing I2C_master on the shared open-drain SCL/SDA bus.
- Exposes a bank of NUM_REGS byte registers, written and read by the master through a pointer byte.
- Runs entirely from the system clock by oversampling SCL/SDA. No clock stretching, no 10-bit or general-call addressing.
- Register contents are presented in parallel to fabric logic.

Parameters:
- SLAVE_ADDR, 7'h42: 7-bit bus address.
- NUM_REGS, 4: number of byte registers; power of two, 2..128.
- REG_RESET, 0: reset value of every register byte.

Ports:
- clk  input  1  system clock; must be ≥ 10× SCL frequency.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- scl_in  input  1  SCL pin level.
- sda_in  input  1  SDA pin level.
- sda_oe  output  1  1 = pull SDA low; 0 = release. Pad drives 0 when set, high-Z otherwise.
- reg_out  output  8*NUM_REGS  register bank; byte k at bits [8k+7:8k].
- wr_strobe  output  1  one-clk pulse when a register byte is written.
- wr_index  output  clog2(NUM_REGS)  index written; valid with wr_strobe.
- busy  output  1  high from address ACK until STOP, repeated START or NACK-terminated read.

Behaviour:
- Reset values: sda_oe=0, wr_strobe=0, wr_index=0, busy=0, pointer=0, all registers=REG_RESET, state=IDLE. Synchronizer flops reset to 1 (bus idle).
- Input conditioning:
  - scl_in and sda_in pass through 2-FF synchronizers, then one more register for edge detection.
  - Events are evaluated on synchronized values only.
- Bus events:
  - START: SDA 1→0 while SCL=1.
  - STOP: SDA 0→1 while SCL=1.
  - Data bits are sampled on SCL rising edge.
  - sda_oe changes only on the clk after an SCL falling edge.
- Event priority, from any state:
  - STOP → IDLE, sda_oe=0, busy=0.
  - START (including repeated START) → ADDR, bit counter cleared, sda_oe=0.
  - START/STOP beat any data edge detected in the same clk.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits MSB first.
    - Bits[7:1]==SLAVE_ADDR → ACK, with R/W latched from bit 0.
    - Mismatch → IDLE, no ACK, sda_oe stays 0.
  - ACK_ADDR: sda_oe=1 from the falling edge after bit 8 to the next falling edge. busy=1.
    - R/W=0 → PTR.
    - R/W=1 → load shift register with reg[pointer], then RDATA.
  - PTR: shift 8 bits. pointer ← byte mod NUM_REGS (low bits). ACK, then WDATA.
  - WDATA: shift 8 bits.
    - reg[pointer] ← byte on the ACK falling edge (bit 8 sampled).
    - wr_strobe pulses 1 clk with wr_index=pointer.
    - pointer increments, wrapping NUM_REGS-1 → 0.
    - ACK, then stay in WDATA for further bytes.
  - RDATA: drive bit 7..0 MSB first. sda_oe = ~bit, updated after each SCL falling edge. pointer increments after bit 0 is driven.
  - RACK: release SDA for the 9th bit; sample master ACK on SCL rise.
    - ACK(0) → load reg[pointer], RDATA.
    - NACK(1) → IDLE, busy=0.
- Wrap: pointer wraps modulo NUM_REGS for both writes and reads.
- Write/read overlap: a register written in a burst is visible on reg_out the clk after wr_strobe.
- STOP mid-byte: partial byte discarded; no write, no strobe.
- Reset mid-transfer: immediate return to reset values; SDA released asynchronously.
- No glitch filter beyond the synchronizers.

Test Plan:
1. Write 2 bytes: S, 0x84, 0x01, 0xAA, 0xBB, P.
   → ACK on all 4 bytes. reg1=0xAA, reg2=0xBB. Two wr_strobe pulses with wr_index 1 then 2. busy low after P.
2. Combined read: S, 0x84, 0x01, Sr, 0x85; master ACKs byte 1, NACKs byte 2; P.
   → Reads return 0xAA, 0xBB. sda_oe=0 after NACK.
3. Wrong address: S, 0x90, ….
   → No ACK (sda_oe never 1). Registers unchanged, busy=0, no wr_strobe.
4. Wrap: write ptr 0x03, then data 0x11, 0x22; also ptr byte 0x07.
   → reg3=0x11, reg0=0x22 (wrap). Pointer byte 0x07 selects reg3.
5. Abort: STOP after 4 bits of a data byte, then reset=0 pulse mid-ACK.
   → No register change from the partial byte. sda_oe=0 immediately on reset. All regs=REG_RESET.
6. Back-to-back: 0x84 with a data byte, then Sr without STOP, new write.
   → Second transaction ACKed and writes land at the new pointer.
